pipeline_lca_adder: RTL and testbench
=====================================

Name: pipeline_lca_adder

Overview:
- 64-bit pipelined carry-lookahead adder: sum = a + b + cin, with carry-out.
- Splits the operand into equal slices. Each slice is one pipeline stage built from two-level carry-lookahead logic.
- Accepts a new operand pair every clock and returns results at a fixed latency.
- Used as a high-throughput datapath adder inside streaming arithmetic blocks.

Parameters:
- WIDTH, 64, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. WIDTH must be divisible by STAGES. Slice width SW = WIDTH/STAGES (16 by default).
- GROUP, 4, bits per first-level lookahead group. SW must be divisible by GROUP.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered result bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- One clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- While rst=1 at a rising edge, every pipeline register clears to 0: slice sums, inter-stage carries, skewed operand copies and output registers. Consequently sum=0 and cout=0 from the edge after reset is asserted.
- No handshake. Inputs are sampled on every rising edge with rst=0. Throughput is one addition per clock. There are no stalls and no bubbles.
- Stage s (0..STAGES-1) adds bits [s*SW+SW-1 : s*SW]:
  - Its carry-in is cin for s=0; otherwise it is the registered carry-out of stage s-1.
  - Per bit: g=a&b, p=a^b. Per GROUP: group generate/propagate.
  - Group carries come from second-level lookahead across the slice.
  - sum bit = p ^ carry. No bit-serial ripple is permitted inside a slice.
- Stage 0 operates combinationally on the live inputs. Its result and the untouched upper operand bits are registered on the capture edge.
- Each later stage consumes the previous stage's registers. Lower-slice results are carried forward through deskew registers so all slices of one addition emerge together.
- Latency: operands sampled at rising edge k appear on sum/cout just after rising edge k+STAGES-1. This is 4 register stages by default, so results change 3 edges after capture.
- Outputs are driven directly from registers, with no combinational path from inputs to outputs.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout. Example: all-ones + 0 + cin=1 gives sum=0, cout=1.
- Carry crossing a slice boundary must propagate correctly through all stages within the same transaction.
- Reset mid-stream:
  - Transactions already in flight are discarded.
  - Outputs read 0 while rst is high and for the following STAGES-1 edges, until the first post-reset operands reach the output.
  - Those zero outputs are the pipeline's cleared contents, which equal 0+0+0.
- Inputs changing every cycle must not corrupt older in-flight transactions, because each stage holds its own operand copy.

Test Plan:
- Reset then a=0, b=200, cin=0 held → after 3 further edges, sum=200, cout=0; outputs are 0 during and immediately after reset.
- Stream a=n, b=200+n, cin=0 with n incrementing each cycle → each output equals 2n+200 exactly 3 edges after capture, one result per clock. Toggle cin=1 for 10 cycles → the corresponding results are 2n+201.
- Slice-boundary carries: a=0x0000_0000_0000_FFFF, b=1 → 0x0000_0000_0001_0000. a=0x0000_FFFF_FFFF_FFFF, cin=1, b=0 → 0x0001_0000_0000_0000, cout=0.
- Wrap-around: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1. a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=1.
- Back-to-back alternation of the all-ones+1 case and the 0+0 case every cycle → outputs alternate (0, cout=1) and (0, cout=0) with no cross-contamination between transactions.
- Assert rst for 1 cycle mid-stream → in-flight results lost; sum=0, cout=0 until the post-reset operands arrive 3 edges later. Compare against a behavioural a+b+cin model delayed by 3 edges.

Source files
------------

// File: rtl/pipeline_lca_adder.sv
// Pipelined carry-lookahead adder: one SW-bit slice per stage, two-level lookahead inside each slice.
// Operand copies shrink and result copies grow stage by stage, so all slices of one addition exit together.
module pipeline_lca_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    // Flat sum-of-products carries at both levels; nothing ripples bit to bit.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic ci);
        logic [SW-1:0] g, p, c;
        logic [NG-1:0] gg, gp, gc;
        logic          term, co;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        gg = '0;
        gp = '1;
        gc = '0;
        co = 1'b0;
        for (int unsigned i = 0; i < NG; i++) begin
            for (int unsigned j = 0; j < GROUP; j++) begin
                term = g[i*GROUP+j];
                for (int unsigned k = j + 1; k < GROUP; k++) term &= p[i*GROUP+k];
                gg[i] |= term;
                gp[i] &= p[i*GROUP+j];
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            term = ci;
            for (int unsigned k = 0; k < i; k++) term &= gp[k];
            gc[i] = term;
            for (int unsigned j = 0; j < i; j++) begin
                term = gg[j];
                for (int unsigned k = j + 1; k < i; k++) term &= gp[k];
                gc[i] |= term;
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            for (int unsigned j = 0; j < GROUP; j++) begin
                term = gc[i];
                for (int unsigned k = 0; k < j; k++) term &= p[i*GROUP+k];
                c[i*GROUP+j] = term;
                for (int unsigned m = 0; m < j; m++) begin
                    term = g[i*GROUP+m];
                    for (int unsigned k = m + 1; k < j; k++) term &= p[i*GROUP+k];
                    c[i*GROUP+j] |= term;
                end
            end
        end
        term = ci;
        for (int unsigned k = 0; k < NG; k++) term &= gp[k];
        co = term;
        for (int unsigned j = 0; j < NG; j++) begin
            term = gg[j];
            for (int unsigned k = j + 1; k < NG; k++) term &= gp[k];
            co |= term;
        end
        return {co, p ^ c};
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int HI = WIDTH - (s + 1) * SW;

        logic [SW-1:0]         in_a, in_b;
        logic                  in_c;
        logic [SW:0]           res;
        logic [(s+1)*SW-1:0]   sum_d, sum_q;
        logic                  carry_d, carry_q;

        if (s == 0) begin : g_head
            always_comb begin
                in_a    = a[SW-1:0];
                in_b    = b[SW-1:0];
                in_c    = cin;
                res     = cla_slice(in_a, in_b, in_c);
                sum_d   = res[SW-1:0];
                carry_d = res[SW];
            end
        end else begin : g_body
            always_comb begin
                in_a    = g_stage[s-1].g_ops.opa_q[SW-1:0];
                in_b    = g_stage[s-1].g_ops.opb_q[SW-1:0];
                in_c    = g_stage[s-1].carry_q;
                res     = cla_slice(in_a, in_b, in_c);
                sum_d   = {res[SW-1:0], g_stage[s-1].sum_q};
                carry_d = res[SW];
            end
        end

        // Only operand bits above this slice travel on to later stages.
        if (HI > 0) begin : g_ops
            logic [HI-1:0] opa_d, opa_q, opb_d, opb_q;

            if (s == 0) begin : g_from_port
                always_comb begin
                    opa_d = a[WIDTH-1:SW];
                    opb_d = b[WIDTH-1:SW];
                end
            end else begin : g_from_prev
                always_comb begin
                    opa_d = g_stage[s-1].g_ops.opa_q[HI+SW-1:SW];
                    opb_d = g_stage[s-1].g_ops.opb_q[HI+SW-1:SW];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
    end

    always_comb begin
        sum  = g_stage[STAGES-1].sum_q;
        cout = g_stage[STAGES-1].carry_q;
    end

endmodule

// File: tb/tb_pipeline_lca_adder.sv
// Directed bench for pipeline_lca_adder: the driver queues hand-computed results with their due edge,
// and an independent monitor checks the outputs on each edge where a result is due.
module tb_pipeline_lca_adder;

    localparam int W   = 64;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        logic [W-1:0] s;
        logic         c;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipeline_lca_adder #(.WIDTH(W), .STAGES(4), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum),
        .cout(cout)
    );

    // Apply one capture's inputs (called #1 after an edge) and queue the hand-computed result.
    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic tr, input logic [W-1:0] es, input logic ec, input string tag);
        exp_t e;
        a   = ta;
        b   = tb;
        cin = tc;
        rst = tr;
        if (tr) begin
            foreach (q[i]) begin
                if (q[i].due >= cyc + 1) begin
                    q[i].s = '0;
                    q[i].c = 1'b0;
                    q[i].tag = {q[i].tag, "_flushed"};
                end
            end
        end
        e.due = cyc + 1 + LAT;
        e.s   = tr ? '0 : es;
        e.c   = tr ? 1'b0 : ec;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                total++;
                if (sum !== e.s || cout !== e.c) begin
                    bad++;
                    $display("FAIL %s edge=%0d got sum=%h cout=%b want sum=%h cout=%b",
                             e.tag, cyc, sum, cout, e.s, e.c);
                end
            end
        end
    end

    initial begin : driver
        logic [W-1:0] ones;
        logic [W-1:0] n;
        logic         c;
        ones = '1;
        @(posedge clk);
        #1;

        repeat (5) step(64'd0, 64'd200, 1'b0, 1'b1, 64'd0, 1'b0, "reset_hold");
        repeat (4) step(64'd0, 64'd200, 1'b0, 1'b0, 64'd200, 1'b0, "first_200");

        for (int i = 0; i < 30; i++) begin
            n = 64'(i);
            c = (i >= 10 && i < 20);
            step(n, 64'd200 + n, c, 1'b0, 64'd200 + 2 * n + 64'(c), 1'b0, "stream");
        end

        step(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "slice0_carry");
        step(64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, "slice2_carry");
        step(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
             64'h0000_0001_0000_0000, 1'b0, "slice1_carry");
        step(ones, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, "wrap_cin");
        step(ones, ones, 1'b1, 1'b0, ones, 1'b1, "ones_ones_cin");
        step(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, "msb_overflow");
        step(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
             64'h2222_2222_2222_2211, 1'b0, "mixed");

        for (int i = 0; i < 4; i++) begin
            step(ones, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, "alt_wrap");
            step(64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, "alt_zero");
        end

        for (int i = 0; i < 6; i++) begin
            n = 64'(i);
            step(n, 64'd1000 + n, 1'b0, 1'b0, 64'd1000 + 2 * n, 1'b0, "pre_reset");
        end
        step(ones, ones, 1'b1, 1'b1, 64'd0, 1'b0, "mid_reset");
        for (int i = 6; i < 12; i++) begin
            n = 64'(i);
            step(n, 64'd1000 + n, 1'b1, 1'b0, 64'd1001 + 2 * n, 1'b0, "post_reset");
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
